lcd_line_fetch: RTL

Line-buffer fetch scheduler that sits between frame memory and the LCD timing driver. It fetches each display line from frame memory in bursts into a ping-pong line buffer, one line ahead of the display. It serves the driver's pixel coordinate requests from the buffer with one-cycle latency. It also flags an underrun when a fetch does not finish before the line it feeds starts.

---
 rtl/lcd_line_fetch_if.sv | 24 ++
 rtl/lcd_line_fetch.sv | 126 ++++++++++++
 2 files changed

// File: rtl/lcd_line_fetch_if.sv
// Frame-memory burst read bus plus the LCD driver's pixel coordinate/data path.
// Combinational signal bundle only: no latency, and the fetch side holds its request until rd_ack.
interface lcd_line_fetch_if #(
    parameter int ADDR_W = 19
);
    logic [10:0]       pixel_xpos;
    logic [10:0]       pixel_ypos;
    logic [15:0]       pixel_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [15:0]       rd_data;

    modport master (
        input  pixel_xpos, pixel_ypos, rd_ack, rd_valid, rd_data,
        output pixel_data, rd_req, rd_addr
    );

    modport slave (
        output pixel_xpos, pixel_ypos, rd_ack, rd_valid, rd_data,
        input  pixel_data, rd_req, rd_addr
    );
endinterface

// File: rtl/lcd_line_fetch.sv
// Ping-pong line buffer fetched one line ahead of the display; pixel read latency 1 cycle, never stalls.
// Memory side holds rd_req/rd_addr until rd_ack and accepts beats with arbitrary gaps; late line starts set underrun.
module lcd_line_fetch #(
    parameter int H_DISP    = 800,
    parameter int V_DISP    = 480,
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 19
) (
    input  logic                    lcd_clk,
    input  logic                    sys_rst_n,
    lcd_line_fetch_if.master        bus,
    output logic                    busy,
    output logic                    underrun,
    input  logic                    underrun_clr
);
    localparam int N_BURST = H_DISP / BURST_LEN;
    localparam int BI_W    = ($clog2(N_BURST) < 1) ? 1 : $clog2(N_BURST);
    localparam int BC_W    = ($clog2(BURST_LEN) < 1) ? 1 : $clog2(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              init_pend;
    logic [BI_W-1:0]   burst_idx;
    logic [BC_W-1:0]   beat_cnt;
    logic [9:0]        wr_ptr;
    logic              tgt_bank;
    logic [ADDR_W-1:0] base;
    logic [15:0]       line_buf [0:2047];

    logic       req_act;
    logic       line_start;
    logic [9:0] col;
    logic       beat;
    logic       burst_done;
    logic       last_burst;
    logic       fetch_go;

    assign req_act    = (bus.pixel_xpos != 11'd0) && (bus.pixel_ypos != 11'd0);
    assign line_start = req_act && (bus.pixel_xpos == 11'd1);
    assign col        = bus.pixel_xpos[9:0] - 10'd1;
    assign beat       = (state == DATA) && bus.rd_valid;
    assign burst_done = beat && (beat_cnt == BC_W'(BURST_LEN - 1));
    assign last_burst = (burst_idx == BI_W'(N_BURST - 1));
    assign fetch_go   = (state == IDLE) && (init_pend || line_start);

    assign busy        = (state != IDLE);
    assign bus.rd_req  = (state == REQ);
    assign bus.rd_addr = base + ADDR_W'(burst_idx) * ADDR_W'(BURST_LEN);

    always_ff @(posedge lcd_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_go) state_nxt = REQ;
            REQ:     if (bus.rd_ack) state_nxt = DATA;
            DATA:    if (burst_done) state_nxt = last_burst ? IDLE : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // The line after the last one wraps to line 1, whose base is address 0.
    always_ff @(posedge lcd_clk) begin
        if (!sys_rst_n) begin
            init_pend <= 1'b1;
            burst_idx <= '0;
            beat_cnt  <= '0;
            wr_ptr    <= '0;
            tgt_bank  <= 1'b0;
            base      <= '0;
        end else if (fetch_go) begin
            init_pend <= 1'b0;
            burst_idx <= '0;
            beat_cnt  <= '0;
            wr_ptr    <= '0;
            if (init_pend) begin
                tgt_bank <= 1'b0;
                base     <= '0;
            end else begin
                tgt_bank <= bus.pixel_ypos[0];
                base     <= (bus.pixel_ypos == 11'(V_DISP)) ? '0
                          : ADDR_W'(bus.pixel_ypos) * ADDR_W'(H_DISP);
            end
        end else if (beat) begin
            wr_ptr   <= wr_ptr + 10'd1;
            beat_cnt <= beat_cnt + BC_W'(1);
            if (burst_done) begin
                beat_cnt <= '0;
                if (!last_burst) burst_idx <= burst_idx + BI_W'(1);
            end
        end
    end

    always_ff @(posedge lcd_clk) begin
        if (sys_rst_n && beat) line_buf[{tgt_bank, wr_ptr}] <= bus.rd_data;
    end

    always_ff @(posedge lcd_clk) begin
        if (!sys_rst_n) begin
            bus.pixel_data <= 16'd0;
        end else if (req_act) begin
            bus.pixel_data <= line_buf[{~bus.pixel_ypos[0], col}];
        end else begin
            bus.pixel_data <= 16'd0;
        end
    end

    // A line start while fetching is dropped; setting outranks a simultaneous clear.
    always_ff @(posedge lcd_clk) begin
        if (!sys_rst_n) begin
            underrun <= 1'b0;
        end else if (line_start && busy) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end
endmodule
